// File: rtl/noc_loopback_pkg.sv
// Shared header layout and header rewrite for the NoC loopback endpoint.
package noc_loopback_pkg;

    localparam int DEST_MSB  = 31;
    localparam int DEST_LSB  = 27;
    localparam int CLASS_MSB = 26;
    localparam int CLASS_LSB = 24;
    localparam int SRC_MSB   = 23;
    localparam int SRC_LSB   = 19;

    // Swap DEST and SRC so the packet travels back to its sender.
    // CLASS and the low payload bits are left untouched.
    function automatic logic [31:0] swap_header(input logic [31:0] flit);
        logic [31:0] r;
        r                    = flit;
        r[DEST_MSB:DEST_LSB] = flit[SRC_MSB:SRC_LSB];
        r[SRC_MSB:SRC_LSB]   = flit[DEST_MSB:DEST_LSB];
        return r;
    endfunction

endpackage

// File: rtl/riscv_noc_loopback_fifo.sv
// Synchronous FIFO of {last, flit} entries, one per loopback channel.
// Output reads straight from storage, so a pushed entry is visible the
// cycle after the push and stays stable until it is popped.
module riscv_noc_loopback_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indexes match.
    assign full    = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    assign empty   = (wptr == rptr);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr[AW-1:0]];

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer update; reset discards everything buffered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/riscv_noc_loopback.sv
// NoC loopback endpoint: buffers each channel's flits, rewrites the header
// so the packet returns to its sender, and counts returned packets.
module riscv_noc_loopback
    import noc_loopback_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  in_flit,
    input  logic [CHANNELS-1:0]                  in_last,
    input  logic [CHANNELS-1:0]                  in_valid,
    output logic [CHANNELS-1:0]                  in_ready,
    output logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  out_flit,
    output logic [CHANNELS-1:0]                  out_last,
    output logic [CHANNELS-1:0]                  out_valid,
    input  logic [CHANNELS-1:0]                  out_ready,
    output logic [CHANNELS-1:0][15:0]            pkt_count
);

    // Handshake: a flit moves when valid and ready are both high at the
    // clock edge. in_ready depends only on occupancy, so a full FIFO refuses
    // a push even in a cycle where it is also popped. out_valid is gated by
    // enable; the head entry is held until popped.

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic                  hdr;
        logic                  push;
        logic                  pop;
        logic                  full;
        logic                  empty;
        logic [FLIT_WIDTH-1:0] wflit;
        logic [FLIT_WIDTH:0]   rdata;
        logic [15:0]           cnt;

        assign push          = in_valid[c] & ~full;
        assign pop           = out_valid[c] & out_ready[c];
        assign in_ready[c]   = ~full;
        assign out_valid[c]  = ~empty & enable;
        assign out_flit[c]   = rdata[FLIT_WIDTH-1:0];
        assign out_last[c]   = rdata[FLIT_WIDTH];
        assign pkt_count[c]  = cnt;

        // Rewrite only flits that start a packet.
        always_comb begin
            wflit = in_flit[c];
            if (hdr) begin
                wflit[31:0] = swap_header(in_flit[c][31:0]);
            end
        end

        // Header tracker: the flit after a last flit starts a new packet.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                hdr <= 1'b1;
            end else if (push) begin
                hdr <= in_last[c];
            end
        end

        // Returned-packet counter, wraps freely.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt <= 16'd0;
            end else if (pop && rdata[FLIT_WIDTH]) begin
                cnt <= cnt + 16'd1;
            end
        end

        riscv_noc_loopback_fifo #(
            .WIDTH (FLIT_WIDTH + 1),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push),
            .wdata ({in_last[c], wflit}),
            .pop   (pop),
            .rdata (rdata),
            .full  (full),
            .empty (empty)
        );
    end

endmodule

// File: tb/tb_riscv_noc_loopback.sv
// Directed bench for riscv_noc_loopback: vector table plus hand sequences.
module tb_riscv_noc_loopback;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [1:0][31:0] in_flit;
    logic [1:0]       in_last;
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0][31:0] out_flit;
    logic [1:0]       out_last;
    logic [1:0]       out_valid;
    logic [1:0]       out_ready;
    logic [1:0][15:0] pkt_count;

    int tests = 0;
    int fails = 0;
    int cnt0  = 0;
    int cnt1  = 0;
    int pops1 = 0;
    logic mon_en = 1'b0;
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];

    typedef struct {
        int          ch;
        logic [31:0] flit;
        logic        last;
        logic [31:0] exp_flit;
    } vec_t;
    vec_t vecs[9];

    riscv_noc_loopback #(.FLIT_WIDTH(32), .CHANNELS(2), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_flit   (in_flit),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pkt_count (pkt_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    // scoreboard monitor: pops happen at the next posedge, inputs are stable here
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid[0] && out_ready[0]) begin
                if (exp_q0.size() == 0) chk("ch0 unexpected flit", out_flit[0], 32'hxxxx_xxxx);
                else begin
                    logic [32:0] e0;
                    e0 = exp_q0.pop_front();
                    chk("ch0 stream flit", out_flit[0], e0[31:0]);
                    chk("ch0 stream last", {31'd0, out_last[0]}, {31'd0, e0[32]});
                    if (e0[32]) cnt0++;
                end
            end
            if (out_valid[1] && out_ready[1]) begin
                pops1++;
                if (exp_q1.size() == 0) chk("ch1 unexpected flit", out_flit[1], 32'hxxxx_xxxx);
                else begin
                    logic [32:0] e1;
                    e1 = exp_q1.pop_front();
                    chk("ch1 stream flit", out_flit[1], e1[31:0]);
                    chk("ch1 stream last", {31'd0, out_last[1]}, {31'd0, e1[32]});
                    if (e1[32]) cnt1++;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 32'h1828_0000, 1'b1, 32'h2818_0000};
        vecs[1] = '{1, 32'h1828_0000, 1'b0, 32'h2818_0000};
        vecs[2] = '{1, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{1, 32'h0000_0001, 1'b1, 32'h0000_0001};
        vecs[4] = '{0, 32'h8C00_1234, 1'b1, 32'h0488_1234};
        vecs[5] = '{1, 32'hF800_0000, 1'b1, 32'h00F8_0000};
        vecs[6] = '{0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
        vecs[7] = '{0, 32'h0007_FFFF, 1'b0, 32'h0007_FFFF};
        vecs[8] = '{0, 32'h1828_0000, 1'b1, 32'h1828_0000};

        rst = 1'b0; enable = 1'b1; in_flit = '0; in_last = '0;
        in_valid = '0; out_ready = '0;
        repeat (2) tick();
        chk("reset in_ready", {30'd0, in_ready}, 32'h3);
        chk("reset out_valid", {30'd0, out_valid}, 32'h0);
        chk("reset pkt_count", {pkt_count[1], pkt_count[0]}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // vector table: one flit at a time, checked one cycle later
        out_ready = 2'b11;
        for (int i = 0; i < 9; i++) begin
            int ch;
            ch = vecs[i].ch;
            in_valid[ch] = 1'b1; in_flit[ch] = vecs[i].flit; in_last[ch] = vecs[i].last;
            #1;
            chk($sformatf("vec%0d in_ready", i), {31'd0, in_ready[ch]}, 32'd1);
            chk($sformatf("vec%0d no bypass", i), {31'd0, out_valid[ch]}, 32'd0);
            tick();
            in_valid[ch] = 1'b0; in_flit[ch] = '0; in_last[ch] = 1'b0;
            #1;
            chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid[ch]}, 32'd1);
            chk($sformatf("vec%0d out_flit", i), out_flit[ch], vecs[i].exp_flit);
            chk($sformatf("vec%0d out_last", i), {31'd0, out_last[ch]}, {31'd0, vecs[i].last});
            if (vecs[i].last) begin
                if (ch == 0) cnt0++; else cnt1++;
            end
            tick();
            chk($sformatf("vec%0d pkt_count", i), {16'd0, pkt_count[ch]},
                (ch == 0) ? cnt0 : cnt1);
        end

        // full / backpressure on ch0
        out_ready = 2'b00;
        for (int i = 0; i < 16; i++) begin
            in_valid[0] = 1'b1;
            in_flit[0]  = (i == 0) ? 32'h1828_0000 : 32'h0000_0100 + i;
            in_last[0]  = (i == 15);
            #1;
            if (!in_ready[0]) chk($sformatf("fill in_ready %0d", i), 32'd0, 32'd1);
            tick();
        end
        in_flit[0] = 32'h0BAD_0017; in_last[0] = 1'b1;
        #1;
        chk("full in_ready", {31'd0, in_ready[0]}, 32'd0);
        out_ready[0] = 1'b1;
        #1;
        chk("full pop in_ready", {31'd0, in_ready[0]}, 32'd0);
        chk("drain hdr", out_flit[0], 32'h2818_0000);
        tick();
        in_valid[0] = 1'b0;
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain valid %0d", i), {31'd0, out_valid[0]}, 32'd1);
            chk($sformatf("drain flit %0d", i), out_flit[0], 32'h0000_0100 + i);
            chk($sformatf("drain last %0d", i), {31'd0, out_last[0]}, {31'd0, i == 15});
            tick();
        end
        cnt0++;
        chk("17th dropped", {31'd0, out_valid[0]}, 32'd0);
        chk("full pkt_count", {16'd0, pkt_count[0]}, cnt0);

        // independence and enable pause
        mon_en = 1'b1;
        out_ready = 2'b10;
        for (int i = 0; i < 12; i++) begin
            in_valid[0] = (i < 3);
            in_flit[0]  = (i == 0) ? 32'h0800_0000 : i;
            in_last[0]  = (i == 2);
            in_valid[1] = (i < 8);
            in_flit[1]  = (i == 0) ? 32'hF800_0000 : 32'hA000_0000 + i;
            in_last[1]  = (i == 7);
            enable      = !(i >= 3 && i < 8);
            #1;
            if (in_valid[0] && in_ready[0])
                exp_q0.push_back({in_last[0], (i == 0) ? 32'h0008_0000 : 32'(i)});
            if (in_valid[1] && in_ready[1])
                exp_q1.push_back({in_last[1], (i == 0) ? 32'h00F8_0000 : 32'hA000_0000 + i});
            if (!enable) chk($sformatf("enable=0 out_valid %0d", i), {30'd0, out_valid}, 32'd0);
            if (i == 3) begin
                chk("ch1 flows while ch0 stalled", {31'd0, pops1 >= 2}, 32'd1);
                chk("ch0 held", exp_q0.size(), 32'd3);
            end
            tick();
        end
        in_valid = '0; enable = 1'b1; out_ready = 2'b11;
        begin
            int budget;
            budget = 0;
            while ((exp_q0.size() != 0 || exp_q1.size() != 0) && budget < 40) begin
                tick();
                budget++;
            end
            chk("stream drain timeout", {31'd0, budget < 40}, 32'd1);
        end
        tick();
        mon_en = 1'b0;
        chk("stream idle", {30'd0, out_valid}, 32'd0);
        chk("stream pkt_count0", {16'd0, pkt_count[0]}, cnt0);
        chk("stream pkt_count1", {16'd0, pkt_count[1]}, cnt1);

        // X data with valid low never stored
        in_flit = 'x;
        tick();
        tick();
        chk("x not stored", {30'd0, out_valid}, 32'd0);
        in_flit = '0;

        // async reset mid-packet
        out_ready = 2'b00;
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1;
            in_flit[0]  = 32'h1828_0000 + i;
            in_last[0]  = 1'b0;
            tick();
        end
        in_valid[0] = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk("async rst out_valid", {30'd0, out_valid}, 32'd0);
        chk("async rst in_ready", {30'd0, in_ready}, 32'h3);
        chk("async rst pkt_count", {pkt_count[1], pkt_count[0]}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        out_ready = 2'b11;
        in_valid[0] = 1'b1; in_flit[0] = 32'h0800_0000; in_last[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        #1;
        chk("post-rst hdr flit", out_flit[0], 32'h0008_0000);
        chk("post-rst hdr last", {31'd0, out_last[0]}, 32'd1);
        tick();
        chk("post-rst pkt_count", {16'd0, pkt_count[0]}, 32'd1);

        // counter wrap
        do_reset();
        out_ready = 2'b11;
        in_flit[0] = 32'h0000_0000; in_last[0] = 1'b1; in_valid[0] = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        in_valid[0] = 1'b0;
        tick();
        chk("wrap count 65535", {16'd0, pkt_count[0]}, 32'h0000_FFFF);
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        chk("wrap count 65536", {16'd0, pkt_count[0]}, 32'h0000_0000);
        chk("wrap ch1 untouched", {16'd0, pkt_count[1]}, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
